univ_shift_reg: RTL and testbench

- Parametrised universal register, WIDTH bits wide, built on synchronous-reset D flip-flops.
- Supports hold, shift, rotate, parallel load, set-all and clear modes, with a global enable.
- Tracks the number of shift/rotate operations since the last load, with a saturating counter and a drained flag.
- Used as the general-purpose storage/serialiser primitive in serial links and datapaths.

---
 rtl/univ_shift_reg.sv | 113 +++++++++++
 tb/tb_univ_shift_reg.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift/rotate/load register with a saturating shift counter and drained flag.
// Optional registered parity output is enabled by defining UNIV_SHIFT_REG_PARITY_EN.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [CNT_W-1:0] cnt,
`ifdef UNIV_SHIFT_REG_PARITY_EN
    output logic             parity,
`endif
    output logic             drained
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHL  = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_ROL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_LOAD = 3'b101,
        MODE_SET  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_nxt;
    logic             sout_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             shift_op;

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        q_nxt    = q;
        sout_nxt = sout;
        cnt_nxt  = cnt;
        shift_op = 1'b0;
        if (en) begin
            case (mode_e'(mode))
                MODE_HOLD: ;
                MODE_SHL: begin
                    q_nxt    = {q[WIDTH-2:0], sin_l};
                    sout_nxt = q[WIDTH-1];
                    shift_op = 1'b1;
                end
                MODE_SHR: begin
                    q_nxt    = {sin_r, q[WIDTH-1:1]};
                    sout_nxt = q[0];
                    shift_op = 1'b1;
                end
                MODE_ROL: begin
                    q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
                    sout_nxt = q[WIDTH-1];
                    shift_op = 1'b1;
                end
                MODE_ROR: begin
                    q_nxt    = {q[0], q[WIDTH-1:1]};
                    sout_nxt = q[0];
                    shift_op = 1'b1;
                end
                MODE_LOAD: begin
                    q_nxt   = d;
                    cnt_nxt = '0;
                end
                MODE_SET: begin
                    q_nxt   = '1;
                    cnt_nxt = '0;
                end
                MODE_CLR: begin
                    q_nxt    = '0;
                    sout_nxt = 1'b0;
                    cnt_nxt  = '0;
                end
                default: ;
            endcase
            // Counter saturates at WIDTH; the shift itself still happens.
            if (shift_op && (cnt < CNT_MAX))
                cnt_nxt = cnt + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= RESET_VAL;
            sout    <= 1'b0;
            cnt     <= '0;
            drained <= 1'b0;
`ifdef UNIV_SHIFT_REG_PARITY_EN
            parity  <= ^RESET_VAL;
`endif
        end else begin
            q       <= q_nxt;
            sout    <= sout_nxt;
            cnt     <= cnt_nxt;
            drained <= (cnt_nxt == CNT_MAX);
`ifdef UNIV_SHIFT_REG_PARITY_EN
            parity  <= ^q_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed test-plan sequences plus randomized
// stimulus against an arithmetic reference model compared every cycle.
module tb_univ_shift_reg;

    localparam int         WIDTH = 8;
    localparam int         CNT_W = 4;
    localparam logic [7:0] RV    = 8'hA5;

    logic             clk = 1'b0;
    logic             rst, en, sin_l, sin_r;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             sout, drained;
    logic [CNT_W-1:0] cnt;
`ifdef UNIV_SHIFT_REG_PARITY_EN
    logic             parity;
`endif

    univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(RV), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout(sout), .cnt(cnt),
`ifdef UNIV_SHIFT_REG_PARITY_EN
        .parity(parity),
`endif
        .drained(drained)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain integers, updated from the behavioural rules.
    int m_q, m_sout, m_cnt;
    bit model_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input bit r, input bit e, input int m, input int dd,
                                       input int sl, input int sr);
        int old;
        old = m_q;
        if (r) begin
            m_q = RV; m_sout = 0; m_cnt = 0;
        end else if (e) begin
            case (m)
                1: begin m_q = (old * 2 + sl) % 256;         m_sout = old / 128; end
                2: begin m_q = old / 2 + sr * 128;           m_sout = old % 2;   end
                3: begin m_q = (old * 2) % 256 + old / 128;  m_sout = old / 128; end
                4: begin m_q = old / 2 + (old % 2) * 128;    m_sout = old % 2;   end
                5: begin m_q = dd;  m_cnt = 0; end
                6: begin m_q = 255; m_cnt = 0; end
                7: begin m_q = 0;   m_cnt = 0; m_sout = 0; end
                default: ;
            endcase
            if (m >= 1 && m <= 4 && m_cnt < WIDTH) m_cnt++;
        end
    endfunction

    function automatic int popcount_parity(input int v);
        int p = 0;
        for (int i = 0; i < WIDTH; i++) p ^= (v >> i) & 1;
        return p;
    endfunction

    // One edge: drive inputs on the falling edge, step the model just after the rising edge.
    task automatic cycle(input bit r, input bit e, input logic [2:0] m, input logic [7:0] dd,
                         input bit sl, input bit sr);
        @(negedge clk);
        rst = r; en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
        @(posedge clk);
        #1;
        model_step(r, e, int'(m), int'(dd), int'(sl), int'(sr));
        model_valid = 1'b1;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            check("q",       32'(q),       32'(m_q));
            check("sout",    32'(sout),    32'(m_sout));
            check("cnt",     32'(cnt),     32'(m_cnt));
            check("drained", 32'(drained), 32'(m_cnt == WIDTH));
`ifdef UNIV_SHIFT_REG_PARITY_EN
            check("parity",  32'(parity),  32'(popcount_parity(m_q)));
`endif
        end
    end

    initial begin
        logic [2:0] rm;
        rst = 1'b0; en = 1'b0; mode = 3'b000; d = '0; sin_l = 1'b0; sin_r = 1'b0;
        repeat (2) @(posedge clk);

        // Reset overrides an enabled load.
        cycle(1, 1, 3'b101, 8'hFF, 0, 0);
        check("rst_q", 32'(q), 32'h A5);
        check("rst_cnt", 32'(cnt), 0);
        check("rst_drained", 32'(drained), 0);
        check("rst_sout", 32'(sout), 0);

        // Load then shift left three times with sin_l=1.
        cycle(0, 1, 3'b101, 8'h81, 0, 0);
        cycle(0, 1, 3'b001, 8'h00, 1, 0);
        check("shl1_sout", 32'(sout), 1);
        cycle(0, 1, 3'b001, 8'h00, 1, 0);
        check("shl2_sout", 32'(sout), 0);
        cycle(0, 1, 3'b001, 8'h00, 1, 0);
        check("shl3_q", 32'(q), 32'h0F);
        check("shl3_sout", 32'(sout), 0);
        check("shl3_cnt", 32'(cnt), 3);

        // Rotate right wraps after WIDTH ops; counter saturates.
        cycle(0, 1, 3'b101, 8'h96, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 3'b100, 8'h00, 0, 0);
        check("ror7_drained", 32'(drained), 0);
        cycle(0, 1, 3'b100, 8'h00, 0, 0);
        check("ror8_q", 32'(q), 32'h96);
        check("ror8_cnt", 32'(cnt), 8);
        check("ror8_drained", 32'(drained), 1);
        cycle(0, 1, 3'b100, 8'h00, 0, 0);
        check("ror9_q", 32'(q), 32'h4B);
        check("ror9_cnt", 32'(cnt), 8);

        // Enable gating.
        cycle(0, 1, 3'b101, 8'h3C, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 3'b001, 8'h00, 1, 1);
        check("en0_q", 32'(q), 32'h3C);
        check("en0_cnt", 32'(cnt), 0);
        cycle(0, 1, 3'b001, 8'h00, 0, 0);
        check("en1_q", 32'(q), 32'h78);
        check("en1_cnt", 32'(cnt), 1);

        // Set, reset priority over set, then clear.
        cycle(0, 1, 3'b110, 8'h00, 0, 0);
        check("set_q", 32'(q), 32'hFF);
        check("set_cnt", 32'(cnt), 0);
        cycle(1, 1, 3'b110, 8'h00, 0, 0);
        check("rst_over_set_q", 32'(q), 32'hA5);
        cycle(0, 1, 3'b001, 8'h00, 0, 0);
        check("pre_clr_sout", 32'(sout), 1);
        cycle(0, 1, 3'b111, 8'h00, 0, 0);
        check("clr_q", 32'(q), 0);
        check("clr_sout", 32'(sout), 0);

`ifdef UNIV_SHIFT_REG_PARITY_EN
        cycle(0, 1, 3'b101, 8'h07, 0, 0);
        check("par_load", 32'(parity), 1);
        cycle(0, 1, 3'b010, 8'h00, 0, 0);
        check("par_shr_q", 32'(q), 32'h03);
        check("par_shr", 32'(parity), 0);
`endif

        // Randomized phase, biased toward shift/rotate so saturation is exercised.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 7) rm = 3'($urandom_range(1, 4));
            else                          rm = 3'($urandom_range(0, 7));
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 8, rm,
                  8'($urandom), 1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
